crc16_ctrl: RTL

CRC16_CTRL -- requirements
Module: crc16_ctrl

---
 rtl/crc16_pkg.sv | 13 +
 rtl/crc16_bitstep.sv | 20 ++
 rtl/crc16_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/crc16_pkg.sv
// crc16_pkg: shared constants and FSM state type for the CRC-16 byte controller.
package crc16_pkg;
  localparam int               CRC16_W        = 16;
  localparam logic [CRC16_W-1:0] CRC16_POLY_USB = 16'h8005;
  localparam logic [CRC16_W-1:0] CRC16_INIT     = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } crc_state_e;
endpackage

// File: rtl/crc16_bitstep.sv
// crc16_bitstep: one MSB-first LFSR step of a CRC-16 (purely combinational).
//   lfsr_i  current LFSR contents
//   bit_i   next message bit
//   poly_i  generator polynomial (implicit x^16 term)
//   lfsr_o  LFSR after absorbing bit_i
module crc16_bitstep
  import crc16_pkg::*;
(
  input  logic [CRC16_W-1:0] lfsr_i,
  input  logic               bit_i,
  input  logic [CRC16_W-1:0] poly_i,
  output logic [CRC16_W-1:0] lfsr_o
);
  logic fb;

  always_comb begin
    fb     = bit_i ^ lfsr_i[CRC16_W-1];
    lfsr_o = {lfsr_i[CRC16_W-2:0], 1'b0} ^ (fb ? poly_i : '0);
  end
endmodule

// File: rtl/crc16_ctrl.sv
// crc16_ctrl: bit-serial CRC-16 over a byte stream, one byte per 9 cycles.
// Bytes arrive on a valid/ready handshake; each accepted byte is shifted into
// the LFSR MSB first over 8 cycles. After the byte flagged s_last the CRC is
// presented on crc_o/crc_valid until crc_ready.
// Ports:
//   clk, reset_l            clock, async active-low reset
//   clr                     synchronous abort of the current packet
//   s_valid/s_ready/s_data/s_last   byte input handshake
//   crc_valid/crc_ready/crc_o       CRC result handshake
//   busy                    controller not IDLE
//   crc_ok                  (only with CRC16_CTRL_CHECK_EN) LFSR was zero at packet end
module crc16_ctrl
  import crc16_pkg::*;
#(
  parameter logic [CRC16_W-1:0] POLY = CRC16_POLY_USB,
  parameter logic [CRC16_W-1:0] INIT = CRC16_INIT
)(
  input  logic               clk,
  input  logic               reset_l,
  input  logic               clr,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  output logic               crc_valid,
  input  logic               crc_ready,
  output logic [CRC16_W-1:0] crc_o,
  output logic               busy
`ifdef CRC16_CTRL_CHECK_EN
  ,output logic              crc_ok
`endif
);
  crc_state_e         state_q, state_d;
  logic [CRC16_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [7:0]         shreg_q, shreg_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               s_hs;
  logic               done_entry;

  crc16_bitstep u_step (
    .lfsr_i (lfsr_q),
    .bit_i  (shreg_q[7]),
    .poly_i (POLY),
    .lfsr_o (lfsr_step)
  );

  assign s_ready   = (state_q == ST_IDLE) || (state_q == ST_WAIT);
  assign s_hs      = s_valid && s_ready;
  assign crc_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign crc_o     = lfsr_q;
  // Last shift of the final byte: the LFSR value about to be presented.
  assign done_entry = (state_q == ST_SHIFT) && (cnt_q == 3'd0) && last_q && !clr;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        // IDLE keeps the preload; WAIT carries the running CRC across bytes.
        if (state_q == ST_IDLE) lfsr_d = INIT;
        if (s_hs) begin
          shreg_d = s_data;
          last_d  = s_last;
          cnt_d   = 3'd7;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        lfsr_d  = lfsr_step;
        shreg_d = {shreg_q[6:0], 1'b0};
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = last_q ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        if (crc_ready) begin
          state_d = ST_IDLE;
          lfsr_d  = INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (clr) begin
      state_d = ST_IDLE;
      lfsr_d  = INIT;
      shreg_d = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      lfsr_q  <= INIT;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

`ifdef CRC16_CTRL_CHECK_EN
  logic crc_ok_q, crc_ok_d;

  // Receiving a message with its CRC appended leaves a zero residue.
  always_comb begin
    crc_ok_d = crc_ok_q;
    if (done_entry) crc_ok_d = (lfsr_step == '0);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) crc_ok_q <= 1'b0;
    else          crc_ok_q <= crc_ok_d;
  end

  assign crc_ok = crc_ok_q;
`else
  logic unused_done_entry;
  assign unused_done_entry = done_entry;
`endif
endmodule
